// File: rtl/register_pkg.sv
// Shared types and constants for the register slice and its upstream feeder.
package register_pkg;

    localparam int WIDTH      = 8;
    localparam int FEED_DEPTH = 8;
    localparam int FEED_GAP_W = 4;

    typedef logic [WIDTH-1:0]              data_t;
    typedef logic [$clog2(FEED_DEPTH)-1:0] ptr_t;

    typedef enum logic {
        FEED_IDLE,
        FEED_GAP
    } feed_state_e;

endpackage

// File: rtl/register_feed_mem.sv
// Feeder FIFO storage: DEPTH x DW flop array, one write port, async read.
// Storage is deliberately not reset; validity is tracked by the pointers.
module register_feed_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Next storage contents: write the addressed entry when enabled.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage flops, no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/register_feed_fifo.sv
// Upstream feeder for the register slice: buffers a valid/ready stream and
// drains it as single-cycle enable pulses, paced by a programmable gap.
// Optional feature macro: REGISTER_FEED_FIFO_HWM_EN adds a high-water-mark port.
module register_feed_fifo
    import register_pkg::*;
#(
    parameter int DW    = register_pkg::WIDTH,
    parameter int DEPTH = 8,
    parameter int GAP_W = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             drain_en,
    input  logic [GAP_W-1:0] gap_cfg,
    output logic             out_enable,
    output logic [DW-1:0]    out_data,
    output logic [CW-1:0]    level,
    output logic             empty,
    output logic             full
`ifdef REGISTER_FEED_FIFO_HWM_EN
    ,
    output logic [CW-1:0]    hwm
`endif
);

    feed_state_e      state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_enable_q, out_enable_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [DW-1:0]    rd_data;
    logic             push;
    logic             pop;

    // Status comes only from the registered count, so in_ready never
    // depends combinationally on in_valid.
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign level    = count_q;

    assign push = in_valid && !full;
    assign pop  = (state_q == FEED_IDLE) && !empty && drain_en;

    register_feed_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Next-state logic for pacing FSM and gap counter.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            FEED_IDLE: begin
                if (pop && (gap_cfg != '0)) begin
                    state_d   = FEED_GAP;
                    gap_cnt_d = gap_cfg;
                end
            end
            FEED_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = FEED_IDLE;
                end
            end
            default: begin
                state_d   = FEED_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    // Pacing FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= FEED_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next pointers, count and output register values.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_enable_d = 1'b0;
        out_data_d   = out_data_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            out_enable_d = 1'b1;
            out_data_d   = rd_data;
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer, count and output registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_enable_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_enable_q <= out_enable_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_enable = out_enable_q;
    assign out_data   = out_data_q;

`ifdef REGISTER_FEED_FIFO_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    // High-water mark tracks the largest next level seen since reset.
    always_comb begin
        hwm_d = hwm_q;
        if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_register_feed_fifo.sv
// Directed self-checking bench for register_feed_fifo, with a small slice
// model capturing out_data on out_enable.
module tb_register_feed_fifo;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic [3:0]    gap_cfg;
    logic          out_enable;
    logic [DW-1:0] out_data;
    logic [CW-1:0] level;
    logic          empty;
    logic          full;
`ifdef REGISTER_FEED_FIFO_HWM_EN
    logic [CW-1:0] hwm;
`endif
    logic [DW-1:0] outa;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    register_feed_fifo #(
        .DW    (DW),
        .DEPTH (8),
        .GAP_W (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .drain_en   (drain_en),
        .gap_cfg    (gap_cfg),
        .out_enable (out_enable),
        .out_data   (out_data),
        .level      (level),
        .empty      (empty),
        .full       (full)
`ifdef REGISTER_FEED_FIFO_HWM_EN
        ,
        .hwm        (hwm)
`endif
    );

    // Register slice model: captures data on the enable pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) outa <= '0;
        else if (out_enable) outa <= out_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        drain_en = 1'b0;
        gap_cfg  = '0;

        // 1: reset
        step();
        step();
        check("rst_out_enable", 32'(out_enable), 0);
        check("rst_out_data",   32'(out_data),   0);
        check("rst_level",      32'(level),      0);
        check("rst_empty",      32'(empty),      1);
        check("rst_full",       32'(full),       0);
        check("rst_in_ready",   32'(in_ready),   1);
`ifdef REGISTER_FEED_FIFO_HWM_EN
        check("rst_hwm", 32'(hwm), 0);
`endif
        reset_n = 1'b1;
        step();

        // 2: single word latency
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        check("t2_level_k",   32'(level),      1);
        check("t2_oe_k",      32'(out_enable), 0);
        step();
        check("t2_oe_k1",     32'(out_enable), 1);
        check("t2_data_k1",   32'(out_data),   32'hA5);
        check("t2_empty_k1",  32'(empty),      1);
        step();
        check("t2_outa_k2",   32'(outa),       32'hA5);
        check("t2_oe_k2",     32'(out_enable), 0);

        // 3: fill to full, refuse 9th, drain back-to-back
        drain_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        check("t3_full",     32'(full),     1);
        check("t3_in_ready", 32'(in_ready), 0);
        check("t3_level",    32'(level),    8);
        in_data = 8'h99;
        step();
        in_valid = 1'b0;
        check("t3_level_9th", 32'(level), 8);
`ifdef REGISTER_FEED_FIFO_HWM_EN
        check("t3_hwm", 32'(hwm), 8);
`endif
        drain_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("t3_oe",   32'(out_enable), 1);
            check("t3_data", 32'(out_data),   32'(i));
        end
        check("t3_empty", 32'(empty), 1);
        step();
        check("t3_oe_after", 32'(out_enable), 0);

        // 4: gap_cfg=3 gives pulse period 4
        drain_en = 1'b0;
        gap_cfg  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            step();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            check("t4_oe", 32'(out_enable), ((c % 4 == 0) && (c < 9)) ? 1 : 0);
            if (c % 4 == 0 && c < 9)
                check("t4_data", 32'(out_data), 32'(8'h11 * (c / 4 + 1)));
        end
        gap_cfg = '0;

        // 5: steady push+pop at level 4 across pointer wrap
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            step();
        end
        check("t5_level_pre", 32'(level), 4);
        drain_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h44 + i);
            step();
            check("t5_level", 32'(level),      4);
            check("t5_oe",    32'(out_enable), 1);
            check("t5_data",  32'(out_data),   32'(8'h40 + i));
        end

        // 6: reset mid-drain while in GAP with level 5
        drain_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + i);
            step();
        end
        in_valid = 1'b0;
        check("t6_level6", 32'(level), 6);
        gap_cfg  = 4'd5;
        drain_en = 1'b1;
        step();
        check("t6_pop_oe",   32'(out_enable), 1);
        check("t6_pop_data", 32'(out_data),   32'h4C);
        check("t6_level5",   32'(level),      5);
        reset_n = 1'b0;
        step();
        check("t6_rst_level", 32'(level),      0);
        check("t6_rst_oe",    32'(out_enable), 0);
        check("t6_rst_empty", 32'(empty),      1);
        check("t6_rst_data",  32'(out_data),   0);
`ifdef REGISTER_FEED_FIFO_HWM_EN
        check("t6_rst_hwm", 32'(hwm), 0);
`endif
        reset_n  = 1'b1;
        gap_cfg  = '0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        check("t6_post_oe",   32'(out_enable), 1);
        check("t6_post_data", 32'(out_data),   32'h77);
        step();
        check("t6_post_outa", 32'(outa), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
